// File: rtl/cam_pkg.sv
// Shared types and constants for the CAM result path.
// Op codes, sentinels and the packed output beat.
package cam_pkg;

  localparam int C_DATA_WIDTH  = 512;
  localparam int LANE_WIDTH    = 32;
  localparam int LANES         = C_DATA_WIDTH / LANE_WIDTH;
  localparam int OP_CODE_WIDTH = 3;

  typedef enum logic [OP_CODE_WIDTH-1:0] {
    IDLE       = 3'd0,
    UPDATE_ALL = 3'd1,
    SEARCH     = 3'd2,
    UPDATE_ONE = 3'd3
  } op_code_e;

  localparam logic [LANE_WIDTH-1:0] ACK_CODE =
    32'd100;
  localparam logic [LANE_WIDTH-1:0] NO_MATCH_PAD =
    32'hFFFF_FFFF;

  typedef struct packed {
    logic [C_DATA_WIDTH-1:0] data;
    logic                    last;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

endpackage

// File: rtl/cam_sync_fifo.sv
// Synchronous FIFO with same-cycle push and pop.
// Head word is held in registers; reads as zero when empty.
module cam_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot a push may fill this cycle.
  always_comb begin
    empty   = (count == '0);
    full    = (count == (AW+1)'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = empty ? '0 : mem[rd_ptr];
  end

  // Storage array; no reset needed on the data.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/cam_result_packer.sv
// Packs CAM results into 512-bit stream beats.
// Buffered so stream backpressure never stalls the CAM.
module cam_result_packer
  import cam_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [OP_CODE_WIDTH-1:0] state,
  input  logic                     s_tvalid,
  input  logic [C_DATA_WIDTH-1:0]  s_tdata,
  input  logic                     flush,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [C_DATA_WIDTH-1:0]  m_tdata,
  output logic                     m_tlast,
  output logic                     overflow,
  output logic [31:0]              result_count
);

  localparam int PTR_W = $clog2(LANES);

  logic [LANES-1:0][LANE_WIDTH-1:0] lane_q;
  logic [LANES-1:0][LANE_WIDTH-1:0] lane_d;
  logic [PTR_W-1:0] lane_ptr;
  logic [PTR_W:0]   fill;
  logic             ack_pending;
  logic             ack_d;
  logic             search;
  logic             ack;
  logic             flush_req;
  logic             full_beat;
  logic             beat_push;
  logic             ack_push;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [C_DATA_WIDTH-1:0] packed_data;
  beat_t            push_beat;
  beat_t            head;
  logic             unused_tdata;

  assign unused_tdata =
    ^s_tdata[C_DATA_WIDTH-1:LANE_WIDTH];

  // Lane fill, batch close and ack sequencing.
  always_comb begin
    search    = s_tvalid && (state == SEARCH);
    ack       = s_tvalid && (state == UPDATE_ALL);
    flush_req = flush || ack;
    lane_d    = lane_q;
    if (search)
      lane_d[lane_ptr] = s_tdata[LANE_WIDTH-1:0];
    fill = {1'b0, lane_ptr} + (PTR_W+1)'(search);
    full_beat = search &&
      (lane_ptr == PTR_W'(LANES-1));
    beat_push = full_beat ||
      (flush_req && (fill != '0));
    ack_push  = ack_pending && !beat_push;
    push      = beat_push || ack_push;
    ack_d     = (ack_pending && !ack_push) ||
                (ack && !ack_pending);
    pop       = m_tvalid && m_tready;
    packed_data = '0;
    for (int k = 0; k < LANES; k++)
      packed_data[k*LANE_WIDTH +: LANE_WIDTH] =
        ((PTR_W+1)'(k) < fill) ? lane_d[k]
                               : NO_MATCH_PAD;
    push_beat = '0;
    unique case (1'b1)
      beat_push: begin
        push_beat.data = packed_data;
        push_beat.last = flush_req;
      end
      ack_push: begin
        push_beat.data =
          {{(C_DATA_WIDTH-LANE_WIDTH){1'b0}},
           ACK_CODE};
        push_beat.last = 1'b1;
      end
      default: push_beat = '0;
    endcase
  end

  // Lane pointer, ack flag, counters and sticky loss.
  always_ff @(posedge aclk) begin
    if (areset) begin
      lane_q       <= '0;
      lane_ptr     <= '0;
      ack_pending  <= 1'b0;
      result_count <= '0;
      overflow     <= 1'b0;
    end else begin
      lane_q      <= lane_d;
      lane_ptr    <= (full_beat || flush_req)
                     ? '0 : fill[PTR_W-1:0];
      ack_pending <= ack_d;
      if (search)
        result_count <= result_count + 32'd1;
      if (push && fifo_full && !pop)
        overflow <= 1'b1;
    end
  end

  cam_sync_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk   (aclk),
    .areset (areset),
    .push   (push),
    .din    (push_beat),
    .pop    (pop),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Stream outputs straight from the FIFO head.
  always_comb begin
    m_tvalid = !fifo_empty;
    m_tdata  = head.data;
    m_tlast  = head.last;
  end

endmodule

// File: tb/tb_cam_result_packer.sv
// Scoreboard bench for cam_result_packer.
// Directed batches; a monitor pops expected beats.
module tb_cam_result_packer;
  import cam_pkg::*;

  localparam int W = C_DATA_WIDTH;

  logic            aclk = 1'b0;
  logic            areset;
  logic [2:0]      state;
  logic            s_tvalid;
  logic [W-1:0]    s_tdata;
  logic            flush;
  logic            m_tvalid;
  logic            m_tready;
  logic [W-1:0]    m_tdata;
  logic            m_tlast;
  logic            overflow;
  logic [31:0]     result_count;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     exp_count = 0;
  bit     rnd_ready = 0;
  beat_t  sb[$];
  beat_t  mon_exp;
  bit     prev_stall = 0;
  logic [W-1:0] prev_data;
  logic   prev_last;

  always #5 aclk = ~aclk;

  cam_result_packer dut (
    .aclk         (aclk),
    .areset       (areset),
    .state        (state),
    .s_tvalid     (s_tvalid),
    .s_tdata      (s_tdata),
    .flush        (flush),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tdata      (m_tdata),
    .m_tlast      (m_tlast),
    .overflow     (overflow),
    .result_count (result_count)
  );

  task automatic chk(input string name,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic beat_t mk_seq(
    input logic [31:0] base,
    input int          n,
    input bit          last);
    beat_t b;
    b.last = last;
    b.data = '0;
    for (int k = 0; k < LANES; k++)
      b.data[k*32 +: 32] = (k < n)
        ? base + 32'(k) : NO_MATCH_PAD;
    return b;
  endfunction

  function automatic beat_t mk_ack();
    beat_t b;
    b.data = '0;
    b.data[31:0] = 32'd100;
    b.last = 1'b1;
    return b;
  endfunction

  task automatic issue(input logic [2:0]  st,
                       input bit          v,
                       input logic [31:0] d,
                       input bit          fl);
    state    = st;
    s_tvalid = v;
    s_tdata  = '0;
    s_tdata[31:0] = d;
    flush    = fl;
    if (rnd_ready) m_tready = 1'($urandom_range(0, 1));
    @(posedge aclk);
    #1;
    if (v && st == SEARCH) exp_count++;
    s_tvalid = 1'b0;
    flush    = 1'b0;
    state    = IDLE;
  endtask

  task automatic search_run(input logic [31:0] base,
                            input int n);
    for (int i = 0; i < n; i++)
      issue(SEARCH, 1'b1, base + 32'(i), 1'b0);
  endtask

  task automatic drain(input string name);
    rnd_ready = 0;
    m_tready  = 1'b1;
    for (int c = 0; c < 300 && sb.size() != 0; c++) begin
      @(posedge aclk);
      #1;
    end
    chk({name, "_left"}, W'(sb.size()), W'(0));
    repeat (2) @(posedge aclk);
    #1;
    chk({name, "_idle"}, W'(m_tvalid), W'(0));
  endtask

  // Monitor: stall stability and scoreboard pops.
  always @(negedge aclk) begin
    if (areset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", W'(m_tvalid), W'(1));
        chk("stall_data", m_tdata, prev_data);
        chk("stall_last", W'(m_tlast), W'(prev_last));
      end
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected none",
                   m_tdata);
        end else begin
          mon_exp = sb.pop_front();
          chk("beat_data", m_tdata, mon_exp.data);
          chk("beat_last", W'(m_tlast), W'(mon_exp.last));
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset   = 1'b1;
    state    = IDLE;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    flush    = 1'b0;
    m_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_valid", W'(m_tvalid), W'(0));
    chk("rst_last", W'(m_tlast), W'(0));
    chk("rst_data", m_tdata, W'(0));
    chk("rst_ovf", W'(overflow), W'(0));
    chk("rst_count", W'(result_count), W'(0));
    areset = 1'b0;
    @(posedge aclk);
    #1;

    // Full beat of 0..15, latency one cycle.
    search_run(0, 15);
    chk("t1_early", W'(m_tvalid), W'(0));
    sb.push_back(mk_seq(0, 16, 1'b0));
    issue(SEARCH, 1'b1, 32'd15, 1'b0);
    chk("t1_latency", W'(m_tvalid), W'(1));
    drain("t1");
    chk("t1_count", W'(result_count), W'(16));

    // Partial beat closed by a lone flush.
    search_run(7, 5);
    sb.push_back(mk_seq(7, 5, 1'b1));
    issue(IDLE, 1'b0, 32'd0, 1'b1);
    drain("t2");
    chk("t2_count", W'(result_count), W'(21));

    // 16th result coincides with flush.
    search_run(500, 15);
    sb.push_back(mk_seq(500, 16, 1'b1));
    issue(SEARCH, 1'b1, 32'd515, 1'b1);
    // Result plus flush on a partial beat.
    search_run(600, 2);
    sb.push_back(mk_seq(600, 3, 1'b1));
    issue(SEARCH, 1'b1, 32'd602, 1'b1);
    // Flush with nothing buffered.
    issue(IDLE, 1'b0, 32'd0, 1'b1);
    drain("t2b");

    // Partial beat then ack beat.
    search_run(200, 3);
    sb.push_back(mk_seq(200, 3, 1'b1));
    sb.push_back(mk_ack());
    issue(UPDATE_ALL, 1'b1, 32'd100, 1'b0);
    drain("t3");
    chk("t3_count", W'(result_count), W'(exp_count));

    // Results outside SEARCH are ignored.
    issue(UPDATE_ONE, 1'b1, 32'd55, 1'b0);
    issue(IDLE, 1'b1, 32'd66, 1'b0);
    issue(IDLE, 1'b0, 32'd0, 1'b1);
    drain("t3b");
    chk("t3b_count", W'(result_count), W'(exp_count));

    // Random backpressure over 64 results.
    for (int b = 0; b < 4; b++)
      sb.push_back(mk_seq(32'd1000 + 32'(16*b), 16, 1'b0));
    rnd_ready = 1;
    search_run(1000, 64);
    drain("t5");
    chk("t5_ovf", W'(overflow), W'(0));

    // Nine batches with no ready: ninth lost.
    m_tready = 1'b0;
    for (int b = 0; b < 9; b++) begin
      if (b < 8)
        sb.push_back(mk_seq(32'd2000 + 32'(16*b), 16, 1'b0));
      search_run(32'd2000 + 32'(16*b), 16);
    end
    chk("t4_ovf", W'(overflow), W'(1));
    drain("t4");
    chk("t4_ovf_sticky", W'(overflow), W'(1));
    chk("t4_count", W'(result_count), W'(exp_count));

    // Reset mid-batch with beats queued.
    m_tready = 1'b0;
    search_run(3000, 39);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    sb.delete();
    exp_count = 0;
    areset = 1'b0;
    chk("t6_valid", W'(m_tvalid), W'(0));
    chk("t6_count", W'(result_count), W'(0));
    chk("t6_ovf", W'(overflow), W'(0));
    m_tready = 1'b1;
    sb.push_back(mk_seq(4000, 16, 1'b0));
    search_run(4000, 16);
    drain("t6");
    chk("t6_count2", W'(result_count), W'(16));

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_result_packer.md
Name: cam_result_packer

Overview:
- Downstream stage of the CAM search kernel. Consumes one result per valid cycle: a match index on search, or the update-complete acknowledge code 100.
- Packs sixteen 32-bit results into each 512-bit output beat.
- Buffers packed beats in a small FIFO so AXI-Stream backpressure never reaches the CAM, which cannot stall.
- Flags loss sticky when the buffer overflows.

Parameters:
- C_DATA_WIDTH, 512, width of input and output data.
- LANE_WIDTH, 32, bits per packed result lane.
- LANES, C_DATA_WIDTH/LANE_WIDTH (16), results per output beat.
- FIFO_DEPTH, 8, packed beats buffered; power of two.
- OP_CODE_WIDTH, 3, width of the CAM state code.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- state  in  OP_CODE_WIDTH  CAM op code: IDLE=0, UPDATE_ALL=1, SEARCH=2, UPDATE_ONE=3.
- s_tvalid  in  1  CAM result valid; no ready, must be taken every cycle.
- s_tdata  in  C_DATA_WIDTH  CAM result; only bits [LANE_WIDTH-1:0] are meaningful.
- flush  in  1  single-cycle pulse marking end of a search batch.
- m_tvalid  out  1  packed beat valid.
- m_tready  in  1  downstream ready.
- m_tdata  out  C_DATA_WIDTH  packed beat; lane k occupies bits [32k+31:32k].
- m_tlast  out  1  beat ends a batch (flush beat or ack beat).
- overflow  out  1  sticky: at least one beat was dropped.
- result_count  out  32  accepted search results since reset; wraps at 2^32.

Behaviour:
- Reset values:
  - m_tvalid=0, m_tlast=0, m_tdata=0, overflow=0, result_count=0.
  - lane_ptr=0, ack_pending=0, FIFO empty.
- Search result (s_tvalid && state==SEARCH):
  - s_tdata[31:0] is written to lane lane_ptr; lane_ptr increments; result_count increments.
  - When the write fills lane LANES-1, the beat is pushed with tlast=0 and lane_ptr returns to 0.
- Flush (flush=1):
  - If lane_ptr>0 after this cycle's write, the partial beat is pushed with tlast=1. Unused lanes are padded with 32'hFFFF_FFFF (no-match sentinel).
  - A result arriving in the same cycle is included before the push.
  - If the 16th result and flush coincide, one full beat is pushed with tlast=1.
  - Flush with lane_ptr==0 and no result pushes nothing.
- Ack (s_tvalid && state==UPDATE_ALL, i.e. s_tdata==100):
  - Sets ack_pending; any partial lanes are flushed as by flush in the same cycle.
  - The ack beat is pushed on the next cycle with no other push: data {480'b0, 32'd100}, tlast=1. ack_pending then clears.
  - A second ack while one is pending is merged (one ack beat).
- s_tvalid in IDLE or UPDATE_ONE: ignored, no state change.
- FIFO write port:
  - One push per cycle. Priority: full/flush beat first, then pending ack.
  - A push attempted when the FIFO is full is dropped and overflow is set; overflow is never cleared except by areset.
  - A simultaneous pop frees a slot in the same cycle, so full with pop is not an overflow.
- Output handshake:
  - m_tdata/m_tlast come from the FIFO head; m_tvalid = FIFO not empty.
  - A beat pops when m_tvalid && m_tready.
  - Head data is stable while m_tvalid && !m_tready.
- Latency: push in cycle N -> m_tvalid at N+1 when the FIFO was empty. Sustained throughput is one beat per cycle.
- Reset mid-batch discards partial lanes, pending ack and FIFO contents.

Decomposition:
- Package cam_pkg holds:
  - state codes IDLE/UPDATE_ALL/SEARCH/UPDATE_ONE;
  - ACK_CODE=100;
  - NO_MATCH_PAD=32'hFFFF_FFFF;
  - LANE_WIDTH;
  - a packed-beat struct {data, last}.
- One sub-module, cam_sync_fifo: synchronous FIFO parameterised on width and depth, with full/empty, same-cycle push+pop, and registered output.

Test Plan:
- 16 SEARCH results 0..15, m_tready=1 -> one beat with lane k=k, tlast=0, m_tvalid one cycle after the 16th; result_count=16.
- 5 results (7,8,9,10,11) then flush -> one beat: lanes 0-4 = 7..11, lanes 5-15 = 32'hFFFF_FFFF, tlast=1.
- 3 results, then an ack cycle in UPDATE_ALL -> partial beat (tlast=1, lanes 3-15 padded), then next beat lane0=100, remaining lanes 0, tlast=1.
- m_tready=0, 9 full batches of 16 results -> FIFO holds 8 beats, 9th dropped, overflow=1 and stays 1. After draining, exactly 8 beats out in order.
- m_tready toggled randomly over 64 results -> 4 beats in order, m_tdata stable while stalled, no overflow.
- areset asserted after 7 results with 2 beats queued -> m_tvalid=0, result_count=0; 16 new results give one clean beat.
